// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared definitions for the VGA raster timing generator.
//               Named video-mode timings (640x480@60, 800x600@60) and helper
//               functions that derive line/frame totals and the reset
//               position of the look-ahead fetch counter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Timing of one raster axis: active region, front porch, sync, back porch
    // and the active level of the sync pulse.
    typedef struct packed {
        logic [15:0] res;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
        logic        pol;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_mode_t;

    // Industry-standard 640x480 @ 60 Hz (25.175 MHz pixel clock), both syncs
    // active-low.
    localparam vga_mode_t c_mode_640x480_60 = '{
        h: '{res: 16'd640, fp: 16'd16, sync: 16'd96,  bp: 16'd48, pol: 1'b0},
        v: '{res: 16'd480, fp: 16'd10, sync: 16'd2,   bp: 16'd33, pol: 1'b0}
    };

    // 800x600 @ 60 Hz (40 MHz pixel clock), both syncs active-high.
    localparam vga_mode_t c_mode_800x600_60 = '{
        h: '{res: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88, pol: 1'b1},
        v: '{res: 16'd600, fp: 16'd1,  sync: 16'd4,   bp: 16'd23, pol: 1'b1}
    };

    // Pixels per line including blanking.
    function automatic int calc_h_total(input int x_res, input int fp,
                                        input int sync, input int bp);
        return x_res + fp + sync + bp;
    endfunction

    // Lines per frame including blanking.
    function automatic int calc_v_total(input int y_res, input int fp,
                                        input int sync, input int bp);
        return y_res + fp + sync + bp;
    endfunction

    // The display counters reset to the last pixel of the frame. The fetch
    // counter sits LOOKAHEAD pixels further on, which wraps into the first
    // line of the next frame whenever LOOKAHEAD is non-zero (LOOKAHEAD is
    // always less than a line).
    function automatic int fetch_rst_x(input int lookahead, input int h_total);
        return (lookahead == 0) ? (h_total - 1) : (lookahead - 1);
    endfunction

    function automatic int fetch_rst_y(input int lookahead, input int v_total);
        return (lookahead == 0) ? (v_total - 1) : 0;
    endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_timing_gen_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : timing_axis_counter
// Description : Parametrised wrapping counter for one raster axis. Counts
//               0..TOTAL-1 on each cycle where i_en is high and wraps to 0.
//               Also exposes its next-state value so downstream decodes can
//               be registered in step with the count itself.
// Ports       : clk     - clock
//               rst_n   - synchronous reset, active-low (loads RESET_VAL)
//               i_en    - advance by one this cycle
//               o_count - current count (registered)
//               o_next  - value the counter will hold after this edge
//               o_wrap  - high when this edge wraps TOTAL-1 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module timing_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL     = 800,
    parameter int WIDTH     = 10,
    parameter int RESET_VAL = 799
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_next,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] c_rst  = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;
    logic             w_at_last;

    always_comb begin
        w_at_last = (r_count_q == c_last);
        w_count_d = r_count_q;
        if (i_en) begin
            // Explicit wrap compare: TOTAL is rarely a power of two, so the
            // counter must never run past TOTAL-1.
            w_count_d = w_at_last ? '0 : (r_count_q + WIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count_q <= c_rst;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_count = r_count_q;
    assign o_next  = w_count_d;
    assign o_wrap  = i_en && w_at_last;

endmodule : timing_axis_counter
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator. Produces X/Y raster
//               counters, registered hsync/vsync with selectable polarity,
//               a display-enable, one-clock line/frame start strobes and a
//               look-ahead fetch coordinate for fixed-latency framebuffer
//               reads. Runs from a fast system clock via pixel_en.
// Ports       : clk             - system/pixel clock
//               rst_n           - synchronous reset, active-low
//               pixel_en        - raster advances one pixel when high
//               counter_x/y     - current raster position
//               hsync/vsync     - sync outputs, polarity per *_SYNC_POL
//               in_display_area - current position is in the active area
//               line_start      - one-clk strobe on entering x=0
//               frame_start     - one-clk strobe on entering (0,0)
//               fetch_x/y       - position LOOKAHEAD pixels ahead
//               fetch_valid     - fetch position is in the active area
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   X_RES         = int'(c_mode_640x480_60.h.res),
    parameter int   Y_RES         = int'(c_mode_640x480_60.v.res),
    parameter int   H_FRONT_PORCH = int'(c_mode_640x480_60.h.fp),
    parameter int   H_SYNC        = int'(c_mode_640x480_60.h.sync),
    parameter int   H_BACK_PORCH  = int'(c_mode_640x480_60.h.bp),
    parameter int   V_FRONT_PORCH = int'(c_mode_640x480_60.v.fp),
    parameter int   V_SYNC        = int'(c_mode_640x480_60.v.sync),
    parameter int   V_BACK_PORCH  = int'(c_mode_640x480_60.v.bp),
    parameter logic H_SYNC_POL    = c_mode_640x480_60.h.pol,
    parameter logic V_SYNC_POL    = c_mode_640x480_60.v.pol,
    parameter int   COUNTER_WIDTH = 10,
    parameter int   LOOKAHEAD     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pixel_en,
    output logic [COUNTER_WIDTH-1:0] counter_x,
    output logic [COUNTER_WIDTH-1:0] counter_y,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     in_display_area,
    output logic                     line_start,
    output logic                     frame_start,
    output logic [COUNTER_WIDTH-1:0] fetch_x,
    output logic [COUNTER_WIDTH-1:0] fetch_y,
    output logic                     fetch_valid
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int c_h_total = calc_h_total(X_RES, H_FRONT_PORCH, H_SYNC, H_BACK_PORCH);
    localparam int c_v_total = calc_v_total(Y_RES, V_FRONT_PORCH, V_SYNC, V_BACK_PORCH);

    localparam int c_fetch_x_rst = fetch_rst_x(LOOKAHEAD, c_h_total);
    localparam int c_fetch_y_rst = fetch_rst_y(LOOKAHEAD, c_v_total);

    // Decode boundaries held at 32 bits so a sync pulse ending exactly at
    // the line/frame total (zero back porch) cannot overflow the counter
    // width.
    localparam logic [31:0] c_x_res    = 32'(X_RES);
    localparam logic [31:0] c_y_res    = 32'(Y_RES);
    localparam logic [31:0] c_hs_start = 32'(X_RES + H_FRONT_PORCH);
    localparam logic [31:0] c_hs_end   = 32'(X_RES + H_FRONT_PORCH + H_SYNC);
    localparam logic [31:0] c_vs_start = 32'(Y_RES + V_FRONT_PORCH);
    localparam logic [31:0] c_vs_end   = 32'(Y_RES + V_FRONT_PORCH + V_SYNC);

    localparam logic c_fetch_valid_rst = (c_fetch_x_rst < X_RES) && (c_fetch_y_rst < Y_RES);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if ((c_h_total - 1) >= (1 << COUNTER_WIDTH)) begin : g_chk_h_width
        $error("vga_timing_gen: H_TOTAL-1 does not fit in COUNTER_WIDTH bits");
    end
    if ((c_v_total - 1) >= (1 << COUNTER_WIDTH)) begin : g_chk_v_width
        $error("vga_timing_gen: V_TOTAL-1 does not fit in COUNTER_WIDTH bits");
    end
    if ((LOOKAHEAD < 0) || (LOOKAHEAD >= c_h_total)) begin : g_chk_lookahead
        $error("vga_timing_gen: LOOKAHEAD must satisfy 0 <= LOOKAHEAD < H_TOTAL");
    end

    // ------------------------------------------------------------------
    // Display and fetch counters
    // ------------------------------------------------------------------
    logic [COUNTER_WIDTH-1:0] w_x_q,  w_x_next;
    logic [COUNTER_WIDTH-1:0] w_y_q,  w_y_next;
    logic [COUNTER_WIDTH-1:0] w_fx_q, w_fx_next;
    logic [COUNTER_WIDTH-1:0] w_fy_q, w_fy_next;
    logic                     w_x_wrap, w_y_wrap, w_fx_wrap;
    // The fetch frame wrap has no consumer: only the display frame wrap
    // produces frame_start.
    logic                     w_unused_fy_wrap;

    timing_axis_counter #(
        .TOTAL     (c_h_total),
        .WIDTH     (COUNTER_WIDTH),
        .RESET_VAL (c_h_total - 1)
    ) u_disp_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (pixel_en),
        .o_count (w_x_q),
        .o_next  (w_x_next),
        .o_wrap  (w_x_wrap)
    );

    // Lines advance only on an enabled end-of-line; w_x_wrap already
    // includes pixel_en.
    timing_axis_counter #(
        .TOTAL     (c_v_total),
        .WIDTH     (COUNTER_WIDTH),
        .RESET_VAL (c_v_total - 1)
    ) u_disp_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_x_wrap),
        .o_count (w_y_q),
        .o_next  (w_y_next),
        .o_wrap  (w_y_wrap)
    );

    // The fetch pair is a free-running copy started LOOKAHEAD pixels
    // further on. Since both pairs see the same enables, the offset holds
    // for ever, including across line and frame wraps.
    timing_axis_counter #(
        .TOTAL     (c_h_total),
        .WIDTH     (COUNTER_WIDTH),
        .RESET_VAL (c_fetch_x_rst)
    ) u_fetch_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (pixel_en),
        .o_count (w_fx_q),
        .o_next  (w_fx_next),
        .o_wrap  (w_fx_wrap)
    );

    timing_axis_counter #(
        .TOTAL     (c_v_total),
        .WIDTH     (COUNTER_WIDTH),
        .RESET_VAL (c_fetch_y_rst)
    ) u_fetch_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_fx_wrap),
        .o_count (w_fy_q),
        .o_next  (w_fy_next),
        .o_wrap  (w_unused_fy_wrap)
    );

    // ------------------------------------------------------------------
    // Registered decodes
    // Decoding the next-state coordinates and registering the result puts
    // the decodes in the same cycle as the counters they describe. When
    // pixel_en is low the next state equals the current state, so the
    // decodes hold without extra logic.
    // ------------------------------------------------------------------
    logic w_hs_active, w_vs_active;
    logic w_hsync_d, w_vsync_d, w_de_d, w_line_start_d, w_frame_start_d, w_fetch_valid_d;
    logic r_hsync_q, r_vsync_q, r_de_q, r_line_start_q, r_frame_start_q, r_fetch_valid_q;

    always_comb begin
        w_hs_active     = (32'(w_x_next) >= c_hs_start) && (32'(w_x_next) < c_hs_end);
        w_vs_active     = (32'(w_y_next) >= c_vs_start) && (32'(w_y_next) < c_vs_end);
        w_hsync_d       = w_hs_active ? H_SYNC_POL : ~H_SYNC_POL;
        w_vsync_d       = w_vs_active ? V_SYNC_POL : ~V_SYNC_POL;
        w_de_d          = (32'(w_x_next) < c_x_res) && (32'(w_y_next) < c_y_res);
        w_fetch_valid_d = (32'(w_fx_next) < c_x_res) && (32'(w_fy_next) < c_y_res);
        // Wrap flags are already gated by pixel_en, so the strobes drop to
        // zero on any disabled cycle.
        w_line_start_d  = w_x_wrap;
        w_frame_start_d = w_y_wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hsync_q       <= ~H_SYNC_POL;
            r_vsync_q       <= ~V_SYNC_POL;
            r_de_q          <= 1'b0;
            r_line_start_q  <= 1'b0;
            r_frame_start_q <= 1'b0;
            r_fetch_valid_q <= c_fetch_valid_rst;
        end else begin
            r_hsync_q       <= w_hsync_d;
            r_vsync_q       <= w_vsync_d;
            r_de_q          <= w_de_d;
            r_line_start_q  <= w_line_start_d;
            r_frame_start_q <= w_frame_start_d;
            r_fetch_valid_q <= w_fetch_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign counter_x       = w_x_q;
    assign counter_y       = w_y_q;
    assign fetch_x         = w_fx_q;
    assign fetch_y         = w_fy_q;
    assign hsync           = r_hsync_q;
    assign vsync           = r_vsync_q;
    assign in_display_area = r_de_q;
    assign line_start      = r_line_start_q;
    assign frame_start     = r_frame_start_q;
    assign fetch_valid     = r_fetch_valid_q;

endmodule : vga_timing_gen
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator and the successor to the fixed 640x480 pixel counter.
- Produces X/Y raster counters, registered hsync/vsync with selectable polarity, and a display-enable.
- Adds one-clock line/frame start strobes, a pixel clock-enable input so it runs from a faster system clock, and a look-ahead fetch coordinate so framebuffer reads with fixed latency arrive aligned to the displayed pixel.
- Sits between the clock/reset block and the pixel pipeline; drives the VGA DAC sync pins.

Parameters:
- X_RES, 640, active pixels per line
- Y_RES, 480, active lines per frame
- H_FRONT_PORCH, 16, pixels after active region before hsync
- H_SYNC, 96, hsync width in pixels
- H_BACK_PORCH, 48, pixels after hsync before next line
- V_FRONT_PORCH, 10, lines after active region before vsync
- V_SYNC, 2, vsync width in lines
- V_BACK_PORCH, 33, lines after vsync before next frame
- H_SYNC_POL, 0, active level of hsync (0 = active-low)
- V_SYNC_POL, 0, active level of vsync
- COUNTER_WIDTH, 10, width of all coordinate outputs; must hold H_TOTAL-1 and V_TOTAL-1
- LOOKAHEAD, 0, fetch-coordinate lead in pixels; 0 <= LOOKAHEAD < H_TOTAL

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  synchronous reset, active-low
- pixel_en  in  1  pixel clock-enable; raster advances one pixel on each clk edge where pixel_en=1
- counter_x  out  COUNTER_WIDTH  current pixel column, 0..H_TOTAL-1
- counter_y  out  COUNTER_WIDTH  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- vsync  out  1  vertical sync, polarity per V_SYNC_POL
- in_display_area  out  1  high when counter_x<X_RES and counter_y<Y_RES
- line_start  out  1  one-clk strobe on entering x=0
- frame_start  out  1  one-clk strobe on entering (0,0)
- fetch_x  out  COUNTER_WIDTH  column LOOKAHEAD pixels ahead of counter_x
- fetch_y  out  COUNTER_WIDTH  line of that look-ahead position
- fetch_valid  out  1  fetch position lies in the active area

Behaviour:
- Derived constants:
  - H_TOTAL = X_RES+H_FRONT_PORCH+H_SYNC+H_BACK_PORCH (800 at default)
  - V_TOTAL likewise (525 at default)
- Counting:
  - counter_x counts 0..H_TOTAL-1 and wraps to 0.
  - counter_y increments only on an x wrap, counts 0..V_TOTAL-1 and wraps to 0.
  - No terminal-count overshoot.
- pixel_en=0:
  - All counters and registered outputs hold.
  - Strobes are forced to 0.
- Reset (rst_n=0 at a clk edge, regardless of pixel_en):
  - counter_x=H_TOTAL-1, counter_y=V_TOTAL-1.
  - hsync and vsync at their inactive level; in_display_area=0; line_start=0; frame_start=0.
  - fetch_x/fetch_y hold the position LOOKAHEAD pixels after (H_TOTAL-1,V_TOTAL-1), i.e. (LOOKAHEAD-1,0) when LOOKAHEAD>0.
  - fetch_valid is decoded from that position.
  - The first enabled edge after reset release enters (0,0) and asserts frame_start and line_start.
  - Reset mid-frame gives identical results.
- Registered decodes: hsync, vsync and in_display_area are registered from next-state coordinates, so they are valid in the same cycle as counter_x/counter_y (zero skew).
  - hsync is active for X_RES+H_FRONT_PORCH <= x < X_RES+H_FRONT_PORCH+H_SYNC (656..751 at default).
  - vsync is active for Y_RES+V_FRONT_PORCH <= y < Y_RES+V_FRONT_PORCH+V_SYNC (490..491).
  - Both are functions of the counters only.
- Strobes:
  - line_start is high for exactly one clk after the enabled edge that loads counter_x=0.
  - frame_start is high for exactly one clk after the edge that loads (0,0); line_start is also high in that cycle.
- Fetch counter:
  - An independent counter pair, advanced by the same pixel_en, that always equals the display position plus LOOKAHEAD modulo the frame.
  - It wraps across line and frame boundaries exactly as the display counters do.
  - With LOOKAHEAD=0 it equals counter_x/counter_y.
  - fetch_valid is registered from the next-state fetch coordinates.
- Parameter checks: elaboration fails if H_TOTAL-1 or V_TOTAL-1 exceeds 2^COUNTER_WIDTH-1, or if LOOKAHEAD >= H_TOTAL.

Decomposition:
- Package vga_timing_pkg holds:
  - named mode constants: 640x480@60, 800x600@60 (front porch, sync, back porch, polarity per mode)
  - helper functions for H_TOTAL and V_TOTAL
- Sub-module timing_axis_counter:
  - one parametrised wrapping counter (TOTAL, WIDTH, reset value) with enable and wrap output
  - instantiated twice for display X/Y and twice for fetch X/Y

Test Plan:
- Reset, then release with pixel_en=1 -> first edge: counter=(0,0), frame_start=1, line_start=1, in_display_area=1; reset holds x=799, y=524, hsync=1, vsync=1 (defaults).
- Free-run one line -> hsync low exactly for x=656..751 (96 clks); in_display_area falls at x=640; x wraps 799->0 with y+1 and one line_start.
- Free-run a full frame -> vsync low for y=490..491 only; y wraps 524->0 with exactly one frame_start per 420000 enabled cycles.
- pixel_en toggling 1,0,1,0 -> counters advance every second clk; strobes last one clk; outputs hold while pixel_en=0.
- LOOKAHEAD=2 -> fetch is always (x+2) modulo the frame:
  - at (798,10): fetch=(0,11)
  - at (799,524): fetch=(1,0), fetch_valid=1
  - at (637,5): fetch_valid=1; at (638,5): fetch_valid=0
- Small mode (X_RES=4, Y_RES=3, porches/syncs=1, COUNTER_WIDTH=3); assert rst_n=0 mid-line -> next clk at reset values; the sequence after release matches the first scenario scaled to the small mode.
